// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman bit packer.
package huffman_pkg;
  localparam int NUM_SYM = 6;
  localparam int CODE_W  = 8;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} pk_state_t;

  typedef struct packed {
    logic [7:0] hc;
    logic [3:0] len;
  } code_entry_t;

  function automatic logic [3:0] popcount8(input logic [CODE_W-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < CODE_W; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction
endpackage

// File: rtl/huffman_code_rom.sv
// Code table latch: stores each symbol's masked code and its length.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              code_valid,
  input  logic [NUM_SYM-1:0][CODE_W-1:0]    hc,
  input  logic [NUM_SYM-1:0][CODE_W-1:0]    m,
  output code_entry_t [NUM_SYM-1:0]         tbl
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tbl <= '0;
    end else if (code_valid) begin
      for (int s = 0; s < NUM_SYM; s++) begin
        tbl[s].hc  <= hc[s] & m[s];
        tbl[s].len <= popcount8(m[s]);
      end
    end
  end
endmodule

// File: rtl/huffman_packer.sv
// Packs variable-length Huffman codes into bytes, oldest bit first in bit 7.
module huffman_packer
  import huffman_pkg::*;
#(
  parameter int BUF_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       code_valid,
  input  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6,
  input  logic [7:0] M1, M2, M3, M4, M5, M6,
  input  logic       sym_valid,
  input  logic [7:0] sym_data,
  output logic       sym_ready,
  input  logic       flush,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  input  logic       byte_ready,
  output logic       done,
  output logic       err
);
  localparam int FW = $clog2(BUF_W + 1);

  pk_state_t                state, state_n;
  code_entry_t [NUM_SYM-1:0] tbl;
  code_entry_t              ent;
  logic [BUF_W-1:0]         acc, acc_n, popped, code_ext;
  logic [FW-1:0]            fill, fill_n, fill_p, sh;
  logic [2:0]               idx;
  logic                     sym_xfer, byte_xfer, legal, bv_n, done_n;

  huffman_code_rom u_rom (
    .clk        (clk),
    .reset_n    (reset_n),
    .code_valid (code_valid),
    .hc         ({HC6, HC5, HC4, HC3, HC2, HC1}),
    .m          ({M6, M5, M4, M3, M2, M1}),
    .tbl        (tbl)
  );

  // Accumulator head is the MSB; new codes land just below the current fill.
  always_comb begin
    sym_xfer  = sym_valid && sym_ready;
    byte_xfer = byte_valid && byte_ready;
    idx       = 3'(sym_data - 8'd1);
    ent       = '0;
    legal     = 1'b0;
    if (sym_data >= 8'd1 && sym_data <= 8'd6) begin
      ent   = tbl[idx];
      legal = (ent.len != 4'd0);
    end
    popped   = byte_xfer ? (acc << 8) : acc;
    fill_p   = byte_xfer ? ((fill >= FW'(8)) ? fill - FW'(8) : '0) : fill;
    code_ext = {{(BUF_W-CODE_W){1'b0}}, ent.hc};
    sh       = FW'(BUF_W) - fill_p - FW'(ent.len);
    acc_n    = popped;
    fill_n   = fill_p;
    if (sym_xfer && legal) begin
      acc_n  = popped | (code_ext << sh);
      fill_n = fill_p + FW'(ent.len);
    end

    state_n = state;
    case (state)
      IDLE:    if (code_valid) state_n = RUN;
      RUN:     if (flush) state_n = FLUSH;
      FLUSH:   if (fill == '0 && !byte_valid) state_n = DONE;
      default: state_n = RUN;
    endcase

    // During FLUSH a short remainder goes out as a zero-padded final byte.
    bv_n   = (fill_n >= FW'(8)) || (state_n == FLUSH && fill_n != '0);
    done_n = ((state == RUN && flush) || (state == FLUSH && byte_xfer)) && fill_n == '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      sym_ready  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      fill       <= fill_n;
      sym_ready  <= (state_n == RUN) && (fill_n <= FW'(BUF_W-8)) && !flush;
      byte_valid <= bv_n;
      byte_data  <= acc_n[BUF_W-1 -: 8];
      done       <= done_n;
      err        <= sym_xfer && !legal;
    end
  end
endmodule
